// File: rtl/clock_pkg.sv
// Shared definitions for the alarm clock time-chain controller:
// mode encoding, BCD field limits and a two-digit BCD increment helper.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HR   = 3'd1,
    SET_MIN  = 3'd2,
    SET_AHR  = 3'd3,
    SET_AMIN = 3'd4
  } mode_t;

  localparam logic [7:0] HR_MAX  = 8'h23;
  localparam logic [7:0] MIN_MAX = 8'h59;
  localparam logic [7:0] SEC_MAX = 8'h59;

  // Next value of a two-digit BCD field, wrapping to 00 after max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD register that advances by one on each inc pulse and
// wraps to 00 after MAX. Holds one alarm field (hour or minute).
import clock_pkg::*;

module bcd2_inc #(
  parameter logic [7:0] MAX = MIN_MAX
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       inc,
  output logic [3:0] H,
  output logic [3:0] L
);

  // Field register: clear on reset, step with wrap on inc.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      {H, L} <= 8'h00;
    end else if (inc) begin
      {H, L} <= bcd_inc({H, L}, MAX);
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Mode/sequencing controller for the alarm clock time chain.
//
//   state    | meaning
//   RUN      | normal timekeeping, alarm may ring
//   SET_HR   | time frozen, inc steps the hours counter
//   SET_MIN  | time frozen, inc steps the minutes counter (no carry)
//   SET_AHR  | time running, inc steps the alarm hour
//   SET_AMIN | time running, inc steps the alarm minute
import clock_pkg::*;

module clock_time_ctrl #(
  parameter int RING_SECS = 60
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       alarm_on,
  input  logic [3:0] SecH,
  input  logic [3:0] SecL,
  input  logic [3:0] MinH,
  input  logic [3:0] MinL,
  input  logic [3:0] HrH,
  input  logic [3:0] HrL,
  output logic       EN_sec,
  output logic       EN_min,
  output logic       EN_hr,
  output logic [2:0] mode,
  output logic [3:0] AlmHrH,
  output logic [3:0] AlmHrL,
  output logic [3:0] AlmMinH,
  output logic [3:0] AlmMinL,
  output logic       ring,
  output logic       blink
);

  localparam int RW = $clog2(RING_SECS + 1);

  mode_t         state_q, state_d;
  logic          mode_prev, inc_prev;
  logic          mode_edge, inc_edge, inc_ok;
  logic          time_frozen, sec_59, sec_00, min_59;
  logic          en_sec_d, en_min_d, en_hr_d, blink_d;
  logic          alm_hr_inc, alm_min_inc, match, ring_stop;
  logic [RW-1:0] ring_cnt;

  assign mode_edge   = btn_mode & ~mode_prev;
  assign inc_edge    = btn_inc & ~inc_prev;
  // A mode change swallows a coincident increment.
  assign inc_ok      = inc_edge & ~mode_edge;
  assign time_frozen = (state_q == SET_HR) || (state_q == SET_MIN);
  assign sec_59      = ({SecH, SecL} == SEC_MAX);
  assign sec_00      = ({SecH, SecL} == 8'h00);
  assign min_59      = ({MinH, MinL} == MIN_MAX);
  assign alm_hr_inc  = (state_q == SET_AHR) && inc_ok;
  assign alm_min_inc = (state_q == SET_AMIN) && inc_ok;
  // Only compared at :00 so the alarm fires once per day.
  assign match       = ~time_frozen & alarm_on & tick_1hz & sec_00 &
                       ({MinH, MinL} == {AlmMinH, AlmMinL}) &
                       ({HrH, HrL} == {AlmHrH, AlmHrL});
  // Any button edge stops the ring; entry to SET_HR/SET_MIN is itself a mode edge.
  assign ring_stop   = ~alarm_on | mode_edge | inc_edge;
  assign mode        = state_q;

  // Button history for rising-edge detection.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      mode_prev <= 1'b0;
      inc_prev  <= 1'b0;
    end else begin
      mode_prev <= btn_mode;
      inc_prev  <= btn_inc;
    end
  end

  // Mode register and registered enable/blink outputs.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_q <= RUN;
      EN_sec  <= 1'b0;
      EN_min  <= 1'b0;
      EN_hr   <= 1'b0;
      blink   <= 1'b0;
    end else begin
      state_q <= state_d;
      EN_sec  <= en_sec_d;
      EN_min  <= en_min_d;
      EN_hr   <= en_hr_d;
      blink   <= blink_d;
    end
  end

  // Next mode, counter enable decode and blink phase.
  always_comb begin
    state_d  = state_q;
    en_sec_d = 1'b0;
    en_min_d = 1'b0;
    en_hr_d  = 1'b0;
    blink_d  = blink;
    if (!time_frozen) begin
      en_sec_d = tick_1hz;
      en_min_d = tick_1hz & sec_59;
      en_hr_d  = tick_1hz & sec_59 & min_59;
    end
    if (state_q == SET_HR)  en_hr_d  = inc_ok;
    if (state_q == SET_MIN) en_min_d = inc_ok;
    if (mode_edge) begin
      blink_d = 1'b0;
      case (state_q)
        RUN:     state_d = SET_HR;
        SET_HR:  state_d = SET_MIN;
        SET_MIN: state_d = SET_AHR;
        SET_AHR: state_d = SET_AMIN;
        default: state_d = RUN;
      endcase
    end else if (state_q == RUN) begin
      blink_d = 1'b0;
    end else if (tick_1hz) begin
      blink_d = ~blink;
    end
  end

  // Ring duration counter; stop events take priority over a new match.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (ring_stop) begin
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else if (match) begin
      ring     <= 1'b1;
      ring_cnt <= RW'(RING_SECS);
    end else if (ring && tick_1hz) begin
      ring_cnt <= ring_cnt - RW'(1);
      if (ring_cnt == RW'(1)) ring <= 1'b0;
    end
  end

  bcd2_inc #(.MAX(HR_MAX)) u_alm_hr (
    .CP  (CP),
    .CR  (CR),
    .inc (alm_hr_inc),
    .H   (AlmHrH),
    .L   (AlmHrL)
  );

  bcd2_inc #(.MAX(MIN_MAX)) u_alm_min (
    .CP  (CP),
    .CR  (CR),
    .inc (alm_min_inc),
    .H   (AlmMinH),
    .L   (AlmMinL)
  );

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: table of RUN decode vectors,
// directed corner-case sequences, and randomized traffic against an
// integer-arithmetic reference model of the controller.
module tb_clock_time_ctrl;
  import clock_pkg::*;

  localparam int RS = 60;

  logic       CP = 1'b0;
  logic       CR, tick_1hz, btn_mode, btn_inc, alarm_on;
  logic [3:0] SecH, SecL, MinH, MinL, HrH, HrL;
  logic       EN_sec, EN_min, EN_hr, ring, blink;
  logic [2:0] mode;
  logic [3:0] AlmHrH, AlmHrL, AlmMinH, AlmMinL;

  clock_time_ctrl #(.RING_SECS(RS)) dut (
    .CP(CP), .CR(CR), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .alarm_on(alarm_on), .SecH(SecH), .SecL(SecL), .MinH(MinH), .MinL(MinL),
    .HrH(HrH), .HrL(HrL), .EN_sec(EN_sec), .EN_min(EN_min), .EN_hr(EN_hr),
    .mode(mode), .AlmHrH(AlmHrH), .AlmHrL(AlmHrL), .AlmMinH(AlmMinH),
    .AlmMinL(AlmMinL), .ring(ring), .blink(blink)
  );

  always #5 CP = ~CP;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state (plain integers)
  int m_mode, m_ahr, m_amin, m_cnt;
  bit m_ring, m_blink, m_pm, m_pi, m_es, m_em, m_eh;

  // observation counters for directed sequences
  int c_es, c_em, c_eh, c_btog;
  bit last_blink;

  function automatic int b2i(logic [3:0] h, logic [3:0] l);
    return int'(h) * 10 + int'(l);
  endfunction

  function automatic logic [7:0] i2b(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_time(int h, int m, int s);
    {HrH, HrL}   = i2b(h);
    {MinH, MinL} = i2b(m);
    {SecH, SecL} = i2b(s);
  endtask

  task automatic model_reset();
    m_mode = 0; m_ahr = 0; m_amin = 0; m_cnt = 0;
    m_ring = 0; m_blink = 0; m_pm = 0; m_pi = 0;
    m_es = 0; m_em = 0; m_eh = 0;
    last_blink = 0;
  endtask

  // Predict the state/outputs after the coming clock edge from current inputs.
  task automatic model_step();
    bit me, ie, keep, match;
    int s, m, h;
    me = btn_mode && !m_pm;
    ie = btn_inc && !m_pi;
    keep = (m_mode != 1) && (m_mode != 2);
    s = b2i(SecH, SecL);
    m = b2i(MinH, MinL);
    h = b2i(HrH, HrL);
    m_es = keep && tick_1hz;
    m_em = m_es && (s == 59);
    m_eh = m_em && (m == 59);
    if (m_mode == 1) m_eh = ie && !me;
    if (m_mode == 2) m_em = ie && !me;
    match = keep && alarm_on && tick_1hz && s == 0 && m == m_amin && h == m_ahr;
    if (!alarm_on || me || ie) begin
      m_ring = 0; m_cnt = 0;
    end else if (match) begin
      m_ring = 1; m_cnt = RS;
    end else if (m_ring && tick_1hz) begin
      m_cnt--;
      if (m_cnt == 0) m_ring = 0;
    end
    if (m_mode == 3 && ie && !me) m_ahr = (m_ahr + 1) % 24;
    if (m_mode == 4 && ie && !me) m_amin = (m_amin + 1) % 60;
    if (me || m_mode == 0) m_blink = 0;
    else if (tick_1hz) m_blink = !m_blink;
    if (me) m_mode = (m_mode + 1) % 5;
    m_pm = btn_mode;
    m_pi = btn_inc;
  endtask

  task automatic step();
    model_step();
    @(posedge CP);
    #1;
    check("model", {EN_sec, EN_min, EN_hr, mode, AlmHrH, AlmHrL, AlmMinH, AlmMinL, ring, blink},
          {m_es, m_em, m_eh, 3'(m_mode), i2b(m_ahr), i2b(m_amin), m_ring, m_blink});
    if (EN_sec) c_es++;
    if (EN_min) c_em++;
    if (EN_hr)  c_eh++;
    if (blink != last_blink) c_btog++;
    last_blink = blink;
  endtask

  task automatic clr_cnt();
    c_es = 0; c_em = 0; c_eh = 0; c_btog = 0;
  endtask

  task automatic pulse_mode();
    btn_mode = 1; step(); btn_mode = 0; step();
  endtask

  task automatic pulse_inc();
    btn_inc = 1; step(); btn_inc = 0; step();
  endtask

  task automatic pulse_tick();
    tick_1hz = 1; step(); tick_1hz = 0; step();
  endtask

  typedef struct {
    int       h, m, s;
    logic     tk;
    logic [2:0] en;
  } vec_t;

  vec_t vt[6];

  initial begin
    int n;
    vt[0] = '{0, 59, 59, 1'b1, 3'b111};
    vt[1] = '{0, 59, 59, 1'b0, 3'b000};
    vt[2] = '{12, 34, 59, 1'b1, 3'b110};
    vt[3] = '{12, 34, 58, 1'b1, 3'b100};
    vt[4] = '{23, 59, 59, 1'b1, 3'b111};
    vt[5] = '{5, 59, 58, 1'b1, 3'b100};

    CR = 1; tick_1hz = 0; btn_mode = 0; btn_inc = 0; alarm_on = 0;
    set_time(0, 0, 0);
    model_reset();
    clr_cnt();
    #12;
    check("reset_state", {EN_sec, EN_min, EN_hr, mode, AlmHrH, AlmHrL, AlmMinH, AlmMinL, ring, blink}, 0);
    @(posedge CP); #1;
    CR = 0;

    // RUN-mode enable decode vectors
    foreach (vt[i]) begin
      set_time(vt[i].h, vt[i].m, vt[i].s);
      tick_1hz = vt[i].tk;
      step();
      check($sformatf("tbl_en%0d", i), {EN_sec, EN_min, EN_hr}, vt[i].en);
    end
    tick_1hz = 0;
    step();
    check("tbl_pulse_end", {EN_sec, EN_min, EN_hr}, 0);

    // SET_HR: increments pulse EN_hr, ticks dropped, blink toggles
    set_time(0, 59, 59);
    pulse_mode();
    check("t2_mode", mode, 3'(SET_HR));
    clr_cnt();
    repeat (3) pulse_inc();
    repeat (5) pulse_tick();
    check("t2_en_hr", c_eh, 3);
    check("t2_en_sec", c_es, 0);
    check("t2_blink", c_btog, 5);

    // simultaneous mode + inc edge: mode wins
    clr_cnt();
    btn_mode = 1; btn_inc = 1; step();
    btn_mode = 0; btn_inc = 0; step();
    check("t3_mode", mode, 3'(SET_MIN));
    check("t3_no_en", c_eh + c_em, 0);
    check("t3_blink", blink, 0);

    // alarm hour and minute wrap
    pulse_mode();
    check("t4_mode", mode, 3'(SET_AHR));
    for (int i = 1; i <= 24; i++) begin
      pulse_inc();
      if (i == 23) check("t4_ahr23", {AlmHrH, AlmHrL}, 8'h23);
    end
    check("t4_ahr_wrap", {AlmHrH, AlmHrL}, 8'h00);
    pulse_mode();
    for (int i = 1; i <= 60; i++) begin
      pulse_inc();
      if (i == 59) check("t4_amin59", {AlmMinH, AlmMinL}, 8'h59);
    end
    check("t4_amin_wrap", {AlmMinH, AlmMinL, AlmHrH, AlmHrL}, 16'h0000);

    // set alarm to 07:30 and let it ring
    pulse_mode();
    repeat (3) pulse_mode();
    repeat (7) pulse_inc();
    pulse_mode();
    repeat (30) pulse_inc();
    pulse_mode();
    check("t5_alarm", {mode, AlmHrH, AlmHrL, AlmMinH, AlmMinL}, {3'(RUN), 16'h0730});
    alarm_on = 1;
    set_time(7, 29, 59);
    pulse_tick();
    check("t5_no_early", ring, 0);
    set_time(7, 30, 0);
    tick_1hz = 1; step();
    check("t5_ring_on", ring, 1);
    tick_1hz = 0; step();
    set_time(7, 30, 1);
    n = 0;
    for (int i = 0; i < RS + 5; i++) begin
      pulse_tick();
      n++;
      if (!ring) break;
    end
    check("t5_ring_len", n, RS);
    alarm_on = 0;
    set_time(7, 30, 0);
    tick_1hz = 1; step();
    check("t5_disarmed", ring, 0);
    tick_1hz = 0; step();

    // async clear mid-ring
    alarm_on = 1;
    tick_1hz = 1; step();
    tick_1hz = 0;
    check("t6_ring_pre", ring, 1);
    #2 CR = 1;
    #1 check("t6_async_clr", {ring, mode, AlmHrH, AlmHrL, AlmMinH, AlmMinL}, 0);
    #2 CR = 0;
    model_reset();

    // inc edge stops ring
    set_time(0, 0, 0);
    tick_1hz = 1; step();
    tick_1hz = 0;
    check("t6_ring2", ring, 1);
    btn_inc = 1; step();
    check("t6_inc_stop", ring, 0);
    btn_inc = 0; step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      alarm_on = ($urandom % 16) != 0;
      if ($urandom % 20 == 0) btn_mode = ~btn_mode;
      if ($urandom % 6 == 0)  btn_inc = ~btn_inc;
      tick_1hz = ($urandom % 3) == 0;
      r = $urandom % 8;
      if (r == 0)      set_time(m_ahr, m_amin, 0);
      else if (r == 1) set_time($urandom % 24, 59, 59);
      else if (r == 2) set_time($urandom % 24, $urandom % 60, 59);
      else             set_time($urandom % 24, $urandom % 60, $urandom % 60);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
